rs_stream_syndrome_engine: RTL and testbench
============================================

// Module: rs_stream_syndrome_engine
// PURPOSE
//  Streaming Reed-Solomon syndrome generator over GF(2^SYM_W) with run-time field polynomial, primitive element and first root.
//  Computes NSYN syndromes S_i = r(first_root*alpha^i) by Horner's rule, time-multiplexed over LANES multipliers.
//  Sits between the bus-side message buffer and the Berlekamp-Massey stage of the decoder pipeline.
// PARAMETERS
//  SYM_W  8   symbol / field width m
//  NSYN   32  syndromes produced (2t); must be a multiple of LANES
//  LANES  4   GF multipliers used per cycle; G = NSYN/LANES groups per symbol
//  CNT_W  8   width of symbol counter
// PORTS
//  clk         in   1            clock
//  rst_n       in   1            async active-low reset
//  start       in   1            begin new block (honoured in IDLE/DONE only)
//  abort       in   1            synchronous return to IDLE from any state
//  cfg_poly    in   SYM_W+1      irreducible polynomial, bit SYM_W must be 1
//  cfg_alpha   in   SYM_W        primitive element
//  cfg_root0   in   SYM_W        first root (alpha^fcr as field element)
//  s_valid     in   1            input symbol valid
//  s_ready     out  1            engine accepts symbol
//  s_data      in   SYM_W        symbol, highest-degree coefficient first
//  s_last      in   1            final symbol of block
//  busy        out  1            high in INIT/RUN
//  syn_valid   out  1            syndromes final; held until start/abort
//  syn_zero    out  1            all syndromes zero (valid with syn_valid)
//  syn_flat    out  NSYN*SYM_W   syndromes, S_0 in LSBs
//  sym_count   out  CNT_W        symbols accepted in current block (saturates)
// BEHAVIOUR
//  Reset: state IDLE; s_ready, busy, syn_valid, syn_zero = 0; syn_flat, sym_count, root regs = 0.
//  States: IDLE -> INIT on start; INIT -> RUN after NSYN cycles; RUN -> DONE when last symbol finishes; DONE -> INIT on start.
//  start latches cfg_poly/cfg_alpha/cfg_root0, clears syn_flat, sym_count, syn_valid, syn_zero. cfg_* ignored afterwards.
//  INIT: one cycle per root: root[0]=cfg_root0, root[i]=root[i-1]*alpha; exactly NSYN cycles, s_ready=0.
//  RUN: handshake fires on s_valid&&s_ready; symbol held in sym_q; group counter g=0..G-1.
//   Cycle g after accept: for k in lanes, j=g*LANES+k: S_j <= S_j*root[j] ^ sym_q.
//   s_ready = RUN && (!processing || (g==G-1 && !last_q)); G=1 gives one symbol per clock.
//   s_last captured with symbol; after its group G-1 cycle -> DONE, syn_valid=1 next cycle,
//   syn_zero = (syn_flat==0) registered on the same edge.
//  s_data/s_last ignored when handshake does not fire; s_valid may drop any cycle without effect.
//  sym_count increments per accepted symbol, saturates at 2^CNT_W-1 (no wrap).
//  abort: any state -> IDLE next edge; syn_valid=0, busy=0, s_ready=0; syn_flat retained but not valid.
//  abort and start same cycle: abort wins. start in INIT/RUN ignored.
//  Field mult: carry-less product reduced by latched cfg_poly[SYM_W-1:0]; all results SYM_W bits.
//  Async reset mid-block discards everything; no partial syndrome survives.
// STRUCTURE
//  Shared include rs_defs.vh: state encodings (IDLE/INIT/RUN/DONE), default SYM_W, MAX_ERRORS.
//  Sub-module gf_mul #(SYM_W): combinational a*b mod poly; LANES+1 instances (lanes + root generator).
//  Top holds FSM, root registers, syndrome registers, group counter.
// TESTING (GF(2^8), cfg_poly=0x11D, alpha=0x02, root0=0x01, NSYN=4, LANES=2)
//  All-zero 8-symbol block -> syn_flat=0, syn_zero=1, sym_count=8, syn_valid 2 G-cycles after last.
//  Block {0x01} -> S=01,01,01,01; syn_zero=0.
//  Block {0x01,0x00} -> S=01,02,04,08; {0x01,0x00,0x00} -> S=01,04,10,40.
//  Random s_valid gaps on 3-symbol block -> same syndromes as gap-free run; s_ready never high in INIT.
//  abort mid-RUN then start -> INIT lasts 4 cycles, prior syndromes cleared, new block correct.
//  rst_n asserted mid-RUN -> all outputs at reset values immediately; LANES=NSYN accepts 1 symbol/clk.

Source files
------------

// File: rtl/rs_stream_syndrome_engine_pkg.sv
// rtl/rs_stream_syndrome_engine_pkg.sv - shared state encoding and defaults for the RS syndrome engine
package rs_stream_syndrome_engine_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } rs_state_e;

  localparam int RS_DEF_SYM_W   = 8;
  localparam int RS_MAX_ERRORS  = 16;

endpackage

// File: rtl/rs_stream_syndrome_engine_gf_mul.sv
// rtl/rs_stream_syndrome_engine_gf_mul.sv - combinational GF(2^m) multiply reduced by a run-time polynomial
module rs_stream_syndrome_engine_gf_mul #(
  parameter int SYM_W = 8
) (
  input  logic [SYM_W-1:0] a,
  input  logic [SYM_W-1:0] b,
  input  logic [SYM_W:0]   poly,
  output logic [SYM_W-1:0] p
);

  logic [SYM_W-1:0] acc;
  logic [SYM_W-1:0] sh;
  logic [SYM_W:0]   t;

  // Shift-and-add: sh walks a*x^i mod poly; poly[SYM_W] cancels the overflow bit.
  always_comb begin
    acc = '0;
    sh  = a;
    t   = '0;
    for (int i = 0; i < SYM_W; i++) begin
      if (b[i]) acc = acc ^ sh;
      t = {sh, 1'b0};
      if (t[SYM_W]) t = t ^ poly;
      sh = t[SYM_W-1:0];
    end
    p = acc;
  end

endmodule

// File: rtl/rs_stream_syndrome_engine.sv
// rtl/rs_stream_syndrome_engine.sv - streaming Reed-Solomon syndrome generator, LANES multipliers time-shared over NSYN roots
module rs_stream_syndrome_engine
  import rs_stream_syndrome_engine_pkg::*;
#(
  parameter int SYM_W = RS_DEF_SYM_W,
  parameter int NSYN  = 2 * RS_MAX_ERRORS,
  parameter int LANES = 4,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [SYM_W:0]        cfg_poly,
  input  logic [SYM_W-1:0]      cfg_alpha,
  input  logic [SYM_W-1:0]      cfg_root0,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [SYM_W-1:0]      s_data,
  input  logic                  s_last,
  output logic                  busy,
  output logic                  syn_valid,
  output logic                  syn_zero,
  output logic [NSYN*SYM_W-1:0] syn_flat,
  output logic [CNT_W-1:0]      sym_count
);

  localparam int G  = NSYN / LANES;
  localparam int GW = (G > 1) ? $clog2(G) : 1;
  localparam int IW = (NSYN > 1) ? $clog2(NSYN) : 1;
  localparam logic [GW-1:0]    G_LAST  = GW'(G - 1);
  localparam logic [IW-1:0]    I_LAST  = IW'(NSYN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  rs_state_e        state_q, state_d;
  logic [SYM_W:0]   poly_q;
  logic [SYM_W-1:0] alpha_q, root0_q, root_last_q, sym_q;
  logic [SYM_W-1:0] root_q [NSYN];
  logic [SYM_W-1:0] syn_q  [NSYN];
  logic [IW-1:0]    init_cnt_q;
  logic [GW-1:0]    g_q;
  logic             proc_q, last_q;

  logic             start_go, accept, grp_end, syn_nz;
  logic [SYM_W-1:0] root_gen, root_next;
  logic [SYM_W-1:0] lane_a [LANES];
  logic [SYM_W-1:0] lane_b [LANES];
  logic [SYM_W-1:0] lane_p [LANES];

  assign start_go  = start && !abort && (state_q == ST_IDLE || state_q == ST_DONE);
  assign s_ready   = (state_q == ST_RUN) && (!proc_q || (g_q == G_LAST && !last_q));
  assign accept    = s_valid && s_ready;
  assign grp_end   = proc_q && (g_q == G_LAST);
  assign busy      = (state_q == ST_INIT) || (state_q == ST_RUN);
  assign root_next = (init_cnt_q == '0) ? root0_q : root_gen;

  rs_stream_syndrome_engine_gf_mul #(.SYM_W(SYM_W)) u_root_gen (
    .a    (root_last_q),
    .b    (alpha_q),
    .poly (poly_q),
    .p    (root_gen)
  );

  // Group g steers syndromes g*LANES .. g*LANES+LANES-1 onto the shared lanes.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      lane_a[k] = '0;
      lane_b[k] = '0;
    end
    for (int j = 0; j < NSYN; j++) begin
      if (g_q == GW'(j / LANES)) begin
        lane_a[j % LANES] = syn_q[j];
        lane_b[j % LANES] = root_q[j];
      end
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    rs_stream_syndrome_engine_gf_mul #(.SYM_W(SYM_W)) u_mul (
      .a    (lane_a[k]),
      .b    (lane_b[k]),
      .poly (poly_q),
      .p    (lane_p[k])
    );
  end

  for (genvar j = 0; j < NSYN; j++) begin : g_flat
    assign syn_flat[j*SYM_W +: SYM_W] = syn_q[j];
  end

  always_comb begin
    syn_nz = 1'b0;
    for (int j = 0; j < NSYN; j++) syn_nz = syn_nz | (syn_q[j] != '0);
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (start)                       state_d = ST_INIT;
        ST_INIT: if (init_cnt_q == I_LAST)        state_d = ST_RUN;
        ST_RUN:  if (grp_end && last_q)           state_d = ST_DONE;
        ST_DONE: if (start)                       state_d = ST_INIT;
        default:                                  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      poly_q      <= '0;
      alpha_q     <= '0;
      root0_q     <= '0;
      root_last_q <= '0;
      sym_q       <= '0;
      init_cnt_q  <= '0;
      g_q         <= '0;
      proc_q      <= 1'b0;
      last_q      <= 1'b0;
      sym_count   <= '0;
      syn_valid   <= 1'b0;
      syn_zero    <= 1'b0;
      for (int j = 0; j < NSYN; j++) begin
        root_q[j] <= '0;
        syn_q[j]  <= '0;
      end
    end else begin
      state_q <= state_d;
      if (abort) begin
        proc_q    <= 1'b0;
        last_q    <= 1'b0;
        g_q       <= '0;
        syn_valid <= 1'b0;
        syn_zero  <= 1'b0;
      end else if (start_go) begin
        poly_q     <= cfg_poly;
        alpha_q    <= cfg_alpha;
        root0_q    <= cfg_root0;
        init_cnt_q <= '0;
        g_q        <= '0;
        proc_q     <= 1'b0;
        last_q     <= 1'b0;
        sym_count  <= '0;
        syn_valid  <= 1'b0;
        syn_zero   <= 1'b0;
        for (int j = 0; j < NSYN; j++) syn_q[j] <= '0;
      end else begin
        case (state_q)
          ST_INIT: begin
            for (int j = 0; j < NSYN; j++) begin
              if (init_cnt_q == IW'(j)) root_q[j] <= root_next;
            end
            root_last_q <= root_next;
            init_cnt_q  <= init_cnt_q + IW'(1);
          end
          ST_RUN: begin
            if (proc_q) begin
              for (int j = 0; j < NSYN; j++) begin
                if (g_q == GW'(j / LANES)) syn_q[j] <= lane_p[j % LANES] ^ sym_q;
              end
            end
            if (accept) begin
              sym_q  <= s_data;
              last_q <= s_last;
              proc_q <= 1'b1;
              g_q    <= '0;
              if (sym_count != CNT_MAX) sym_count <= sym_count + CNT_W'(1);
            end else if (grp_end) begin
              proc_q <= 1'b0;
              g_q    <= '0;
            end else if (proc_q) begin
              g_q <= g_q + GW'(1);
            end
          end
          // Syndromes settle on the edge into DONE, so flag and zero test follow one edge later.
          ST_DONE: begin
            if (!syn_valid) begin
              syn_valid <= 1'b1;
              syn_zero  <= !syn_nz;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rs_stream_syndrome_engine.sv
// tb/tb_rs_stream_syndrome_engine.sv - self-checking bench for rs_stream_syndrome_engine
module tb_rs_stream_syndrome_engine;

  localparam int NSYN = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, start_b = 1'b0, abort = 1'b0;
  logic [8:0]  cfg_poly = 9'h11D;
  logic [7:0]  cfg_alpha = 8'h02, cfg_root0 = 8'h01;
  logic        s_valid = 1'b0, s_last = 1'b0, sv_b = 1'b0, sl_b = 1'b0;
  logic [7:0]  s_data = 8'h00, sd_b = 8'h00;
  logic        s_ready, busy, syn_valid, syn_zero;
  logic        rdy_b, busy_b, sval_b, szero_b;
  logic [31:0] syn_flat, flat_b;
  logic [7:0]  sym_count, cnt_b;

  int checks = 0;
  int failures = 0;

  logic [8:0] m_poly;
  logic [7:0] m_alpha, m_root0;
  logic [7:0] blk[$];

  always #5 clk = ~clk;

  rs_stream_syndrome_engine #(.SYM_W(8), .NSYN(NSYN), .LANES(2), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_poly(cfg_poly), .cfg_alpha(cfg_alpha), .cfg_root0(cfg_root0),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .busy(busy), .syn_valid(syn_valid), .syn_zero(syn_zero),
    .syn_flat(syn_flat), .sym_count(sym_count)
  );

  rs_stream_syndrome_engine #(.SYM_W(8), .NSYN(NSYN), .LANES(NSYN), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort),
    .cfg_poly(cfg_poly), .cfg_alpha(cfg_alpha), .cfg_root0(cfg_root0),
    .s_valid(sv_b), .s_ready(rdy_b), .s_data(sd_b), .s_last(sl_b),
    .busy(busy_b), .syn_valid(sval_b), .syn_zero(szero_b),
    .syn_flat(flat_b), .sym_count(cnt_b)
  );

  // Reference field arithmetic: full polynomial product, then long division by m_poly.
  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] prod;
    prod = '0;
    for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ ({8'h00, a} << i);
    for (int d = 15; d >= 8; d--) if (prod[d]) prod = prod ^ ({7'h00, m_poly} << (d - 8));
    return prod[7:0];
  endfunction

  function automatic logic [7:0] ref_pow(input logic [7:0] x, input int e);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < e; i++) r = ref_mul(r, x);
    return r;
  endfunction

  // S_i = sum_k blk[k] * x_i^(n-1-k), x_i = root0 * alpha^i
  function automatic logic [31:0] ref_flat();
    logic [31:0] f;
    logic [7:0]  x, s;
    int n;
    n = blk.size();
    f = '0;
    for (int i = 0; i < NSYN; i++) begin
      x = ref_mul(m_root0, ref_pow(m_alpha, i));
      s = 8'h00;
      for (int k = 0; k < n; k++) s = s ^ ref_mul(blk[k], ref_pow(x, n - 1 - k));
      f[i*8 +: 8] = s;
    end
    return f;
  endfunction

  function automatic logic get_rdy(input bit sel);    return sel ? rdy_b  : s_ready;   endfunction
  function automatic logic get_busy(input bit sel);   return sel ? busy_b : busy;      endfunction
  function automatic logic get_valid(input bit sel);  return sel ? sval_b : syn_valid; endfunction
  function automatic logic get_zero(input bit sel);   return sel ? szero_b : syn_zero; endfunction
  function automatic logic [31:0] get_flat(input bit sel); return sel ? flat_b : syn_flat; endfunction
  function automatic logic [7:0]  get_cnt(input bit sel);  return sel ? cnt_b  : sym_count; endfunction

  task automatic randomize_cfg();
    m_poly  = {1'b1, 8'($urandom)};
    m_alpha = 8'($urandom_range(1, 255));
    m_root0 = 8'($urandom_range(1, 255));
  endtask

  task automatic do_start(input bit sel);
    @(negedge clk);
    cfg_poly = m_poly; cfg_alpha = m_alpha; cfg_root0 = m_root0;
    if (sel) start_b = 1'b1; else start = 1'b1;
    @(negedge clk);
    start = 1'b0; start_b = 1'b0;
    cfg_poly = {1'b1, 8'($urandom)}; cfg_alpha = 8'($urandom); cfg_root0 = 8'($urandom);
    checks++;
    if (get_flat(sel) !== 32'h0 || get_cnt(sel) !== 8'h0 || get_valid(sel) !== 1'b0) begin
      failures++;
      $display("FAIL start_clear flat=%h cnt=%0d valid=%b required 0/0/0", get_flat(sel), get_cnt(sel), get_valid(sel));
    end
    for (int c = 0; c < NSYN; c++) begin
      checks++;
      if (get_rdy(sel) !== 1'b0 || get_busy(sel) !== 1'b1) begin
        failures++;
        $display("FAIL init_window cycle=%0d s_ready=%b busy=%b required 0/1", c, get_rdy(sel), get_busy(sel));
      end
      @(negedge clk);
    end
    checks++;
    if (get_rdy(sel) !== 1'b1) begin
      failures++;
      $display("FAIL init_end s_ready=%b required 1", get_rdy(sel));
    end
  endtask

  task automatic send_block(input bit sel, input int gap_pct, output int cyc);
    int  idx;
    logic v, l;
    logic [7:0] d;
    idx = 0;
    cyc = 0;
    while (idx < blk.size() && cyc < 5000) begin
      @(negedge clk);
      if ($urandom_range(99) < gap_pct) begin
        v = 1'b0; d = 8'($urandom); l = 1'($urandom);
      end else begin
        v = 1'b1; d = blk[idx]; l = (idx == blk.size() - 1);
      end
      if (sel) begin sv_b = v; sd_b = d; sl_b = l; end
      else begin s_valid = v; s_data = d; s_last = l; end
      #1;
      if (v && get_rdy(sel)) idx++;
      cyc++;
    end
    @(negedge clk);
    s_valid = 1'b0; sv_b = 1'b0;
    if (idx < blk.size()) begin
      checks++; failures++;
      $display("FAIL send_timeout sent=%0d required %0d", idx, blk.size());
    end
  endtask

  task automatic wait_done(input bit sel, output int lat);
    lat = 0;
    while (get_valid(sel) !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    checks++;
    if (s_ready !== 1'b0 || busy !== 1'b0 || syn_valid !== 1'b0 || syn_zero !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags rdy=%b busy=%b valid=%b zero=%b required all 0", s_ready, busy, syn_valid, syn_zero);
    end
    checks++;
    if (syn_flat !== 32'h0 || sym_count !== 8'h0) begin
      failures++;
      $display("FAIL reset_data flat=%h cnt=%0d required 0/0", syn_flat, sym_count);
    end
  endtask

  task automatic test_known_vectors();
    logic [31:0] exp_flat;
    int cyc, lat;
    m_poly = 9'h11D; m_alpha = 8'h02; m_root0 = 8'h01;
    for (int v = 0; v < 4; v++) begin
      blk.delete();
      case (v)
        0: begin for (int i = 0; i < 8; i++) blk.push_back(8'h00); exp_flat = 32'h0000_0000; end
        1: begin blk.push_back(8'h01); exp_flat = 32'h0101_0101; end
        2: begin blk.push_back(8'h01); blk.push_back(8'h00); exp_flat = 32'h0804_0201; end
        default: begin blk.push_back(8'h01); blk.push_back(8'h00); blk.push_back(8'h00); exp_flat = 32'h4010_0401; end
      endcase
      do_start(1'b0);
      send_block(1'b0, 0, cyc);
      wait_done(1'b0, lat);
      checks++;
      if (syn_flat !== exp_flat) begin failures++; $display("FAIL known_flat v=%0d got=%h required=%h", v, syn_flat, exp_flat); end
      checks++;
      if (syn_zero !== (exp_flat == 0)) begin failures++; $display("FAIL known_zero v=%0d got=%b required=%b", v, syn_zero, exp_flat == 0); end
      checks++;
      if (sym_count !== 8'(blk.size())) begin failures++; $display("FAIL known_count v=%0d got=%0d required=%0d", v, sym_count, blk.size()); end
      checks++;
      if (lat != 3) begin failures++; $display("FAIL known_latency v=%0d got=%0d required=3", v, lat); end
      checks++;
      if (cyc != 2 * blk.size() - 1) begin failures++; $display("FAIL known_rate v=%0d got=%0d required=%0d", v, cyc, 2 * blk.size() - 1); end
      repeat (3) @(negedge clk);
      checks++;
      if (syn_valid !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b0) begin
        failures++;
        $display("FAIL known_hold v=%0d valid=%b busy=%b rdy=%b required 1/0/0", v, syn_valid, busy, s_ready);
      end
    end
  endtask

  task automatic test_random_gaps(input bit sel, input int iters);
    logic [31:0] exp_flat;
    int cyc, lat, n;
    for (int it = 0; it < iters; it++) begin
      randomize_cfg();
      blk.delete();
      n = $urandom_range(1, 10);
      if (it < 2) n = 3;
      for (int i = 0; i < n; i++) blk.push_back(8'($urandom));
      exp_flat = ref_flat();
      do_start(sel);
      send_block(sel, (it % 2) ? 60 : 0, cyc);
      wait_done(sel, lat);
      checks++;
      if (get_flat(sel) !== exp_flat) begin failures++; $display("FAIL rand_flat sel=%0d it=%0d got=%h required=%h", sel, it, get_flat(sel), exp_flat); end
      checks++;
      if (get_zero(sel) !== (exp_flat == 0)) begin failures++; $display("FAIL rand_zero sel=%0d it=%0d got=%b", sel, it, get_zero(sel)); end
      checks++;
      if (get_cnt(sel) !== 8'(n)) begin failures++; $display("FAIL rand_count sel=%0d it=%0d got=%0d required=%0d", sel, it, get_cnt(sel), n); end
      checks++;
      if (lat != (sel ? 2 : 3)) begin failures++; $display("FAIL rand_latency sel=%0d it=%0d got=%0d required=%0d", sel, it, lat, sel ? 2 : 3); end
      if (it % 2 == 0) begin
        checks++;
        if (cyc != (sel ? n : 2 * n - 1)) begin failures++; $display("FAIL rand_rate sel=%0d it=%0d got=%0d required=%0d", sel, it, cyc, sel ? n : 2 * n - 1); end
      end
    end
  endtask

  task automatic test_abort();
    logic [31:0] exp_flat;
    int cyc, lat;
    randomize_cfg();
    do_start(1'b0);
    @(negedge clk); s_valid = 1'b1; s_data = 8'hA5; s_last = 1'b0;
    @(negedge clk); s_valid = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    checks++;
    if (sym_count !== 8'd1 || busy !== 1'b1) begin failures++; $display("FAIL start_in_run cnt=%0d busy=%b required 1/1", sym_count, busy); end
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || s_ready !== 1'b0 || syn_valid !== 1'b0) begin
      failures++; $display("FAIL abort_flags busy=%b rdy=%b valid=%b required 0/0/0", busy, s_ready, syn_valid);
    end
    checks++;
    if (syn_flat !== 32'h0000_A5A5) begin failures++; $display("FAIL abort_retain got=%h required=0000a5a5", syn_flat); end
    abort = 1'b1; start = 1'b1;
    @(negedge clk); abort = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL abort_wins busy=%b required 0", busy); end
    blk.delete();
    for (int i = 0; i < 5; i++) blk.push_back(8'($urandom));
    exp_flat = ref_flat();
    do_start(1'b0);
    send_block(1'b0, 30, cyc);
    wait_done(1'b0, lat);
    checks++;
    if (syn_flat !== exp_flat) begin failures++; $display("FAIL abort_restart got=%h required=%h", syn_flat, exp_flat); end
  endtask

  task automatic test_back_to_back_saturate();
    logic [31:0] exp_flat;
    int cyc, lat;
    randomize_cfg();
    blk.delete();
    for (int i = 0; i < 300; i++) blk.push_back(8'($urandom));
    exp_flat = ref_flat();
    do_start(1'b1);
    send_block(1'b1, 0, cyc);
    wait_done(1'b1, lat);
    checks++;
    if (cnt_b !== 8'hFF) begin failures++; $display("FAIL sat_count got=%0d required=255", cnt_b); end
    checks++;
    if (cyc != 300) begin failures++; $display("FAIL b2b_rate got=%0d required=300", cyc); end
    checks++;
    if (flat_b !== exp_flat) begin failures++; $display("FAIL sat_flat got=%h required=%h", flat_b, exp_flat); end
  endtask

  task automatic test_reset_mid_run();
    randomize_cfg();
    do_start(1'b0);
    @(negedge clk); s_valid = 1'b1; s_data = 8'h3C; s_last = 1'b0;
    @(negedge clk); s_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (s_ready !== 1'b0 || busy !== 1'b0 || syn_valid !== 1'b0 || syn_zero !== 1'b0 ||
        syn_flat !== 32'h0 || sym_count !== 8'h0) begin
      failures++;
      $display("FAIL reset_mid_run rdy=%b busy=%b valid=%b flat=%h cnt=%0d required all 0", s_ready, busy, syn_valid, syn_flat, sym_count);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || syn_flat !== 32'h0) begin failures++; $display("FAIL reset_release busy=%b flat=%h required 0/0", busy, syn_flat); end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_known_vectors();
    test_random_gaps(1'b0, 8);
    test_abort();
    test_random_gaps(1'b1, 4);
    test_back_to_back_saturate();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
